// File: rtl/hd_err_monitor_pkg.sv
// Shared helpers for the Hamming-distance error monitor: HD width calculation,
// wide popcount and saturating accumulator addition.
// No latency (functions only); no backpressure involvement.
package hd_mon_pkg;

    // Upper bound on vector width handled by popcount (callers zero-extend).
    localparam int POP_MAX_W = 256;
    // Upper bound on accumulator width handled by sat_add (callers zero-extend).
    localparam int SAT_MAX_W = 64;

    // Bits needed to hold a Hamming distance of a w-bit vector (0..w).
    function automatic int hd_w_calc(input int w);
        return $clog2(w + 1);
    endfunction

    // Number of set bits; unused upper bits must be zero.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

    // acc + inc, clamped to the all-ones value of a w-bit accumulator (w < 64).
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] inc,
        input int                   w
    );
        logic [SAT_MAX_W:0] one;
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        one = (SAT_MAX_W+1)'(1);
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (one << w) - one;
        if (sum > lim) begin
            return lim[SAT_MAX_W-1:0];
        end else begin
            return sum[SAT_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/hd_err_monitor_if.sv
// Stream and statistics bundle of the Hamming-distance monitor.
// No latency (wires only); carries the in/out valid-ready pairs.
// Ports: in_valid/in_ready/a/b, out_valid/out_ready/out_hd/out_viol, statistics,
// and cap_* when HD_MON_CAPTURE_EN is defined. slave = monitor, master = driver.
interface hd_err_monitor_if #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 32
);
    import hd_mon_pkg::*;

    localparam int HD_W = hd_w_calc(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [HD_W-1:0]  out_hd;
    logic             out_viol;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] viol_cnt;
    logic [CNT_W-1:0] hd_sum;
    logic [HD_W-1:0]  hd_max;
    logic             alarm;
`ifdef HD_MON_CAPTURE_EN
    logic             cap_valid;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [CNT_W-1:0] cap_idx;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_hd, out_viol,
        output sample_cnt, viol_cnt, hd_sum, hd_max, alarm,
        output cap_valid, cap_a, cap_b, cap_idx
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_hd, out_viol,
        input  sample_cnt, viol_cnt, hd_sum, hd_max, alarm,
        input  cap_valid, cap_a, cap_b, cap_idx
    );
`else
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_hd, out_viol,
        output sample_cnt, viol_cnt, hd_sum, hd_max, alarm
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_hd, out_viol,
        input  sample_cnt, viol_cnt, hd_sum, hd_max, alarm
    );
`endif

endinterface

// File: rtl/hd_err_monitor_popcount_half.sv
// Registered popcount of one half-slice of the a^b difference vector.
// Latency 1 cycle; result updates only when i_en is high.
// Backpressure: i_en low holds the registered count (pipeline stall).
// Ports: clk, rst (async high), i_en, i_vec[W], o_cnt[OUT_W].
module hd_popcount_half
    import hd_mon_pkg::*;
#(
    parameter int W     = 9,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [W-1:0]     i_vec,
    output logic [OUT_W-1:0] o_cnt
);

    logic [OUT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= OUT_W'(popcount(POP_MAX_W'(i_vec)));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hd_err_monitor.sv
// Pipelined Hamming-distance monitor: HD = popcount(a^b), flags HD > THRESH, keeps run statistics.
// Latency 2 cycles accept-to-out_valid; throughput 1 beat/cycle.
// Backpressure: out_valid & ~out_ready stalls both stages and drops in_ready.
// Ports: clk, rst (async high), clear (sync stats clear), mon (hd_err_monitor_if.slave).
// Optional macro HD_MON_CAPTURE_EN adds capture of the first violating sample (cap_*).
module hd_err_monitor
    import hd_mon_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int THRESH = 6,
    parameter int CNT_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    hd_err_monitor_if.slave mon
);

    localparam int HD_W   = hd_w_calc(WIDTH);
    localparam int LO_W   = (WIDTH + 1) / 2;
    localparam int XP_W   = 2 * LO_W;
    localparam int HALF_W = hd_w_calc(LO_W);
    localparam logic [HD_W-1:0] THRESH_HD = HD_W'(THRESH);

    logic             w_stall;
    logic             w_en;
    logic             w_load2;
    logic             w_viol;
    logic [WIDTH-1:0] w_x;
    logic [XP_W-1:0]  w_x_pad;
    logic [HALF_W-1:0] w_lo_cnt;
    logic [HALF_W-1:0] w_hi_cnt;
    logic [HD_W-1:0]  w_hd;

    logic             r_v1;
    logic             r_out_vld;
    logic [HD_W-1:0]  r_out_hd;
    logic             r_out_viol;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_viol_cnt;
    logic [CNT_W-1:0] r_hd_sum;
    logic [HD_W-1:0]  r_hd_max;
    logic             r_alarm;

    assign w_stall = r_out_vld & ~mon.out_ready;
    assign w_en    = ~w_stall;
    // A sample enters S2 (and is accounted) exactly when S1 holds one and we are not stalled.
    assign w_load2 = w_en & r_v1;

    // Odd widths: upper slice is zero-padded so both halves share one popcount shape.
    assign w_x     = mon.a ^ mon.b;
    assign w_x_pad = XP_W'(w_x);

    hd_popcount_half #(.W(LO_W), .OUT_W(HALF_W)) u_pc_lo (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_vec (w_x_pad[LO_W-1:0]),
        .o_cnt (w_lo_cnt)
    );

    hd_popcount_half #(.W(LO_W), .OUT_W(HALF_W)) u_pc_hi (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_vec (w_x_pad[XP_W-1:LO_W]),
        .o_cnt (w_hi_cnt)
    );

    assign w_hd   = HD_W'(w_lo_cnt) + HD_W'(w_hi_cnt);
    assign w_viol = w_hd > THRESH_HD;

    // S1 valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= mon.in_valid;
        end
    end

    // S2 output register; data only moves on a real sample so bubbles keep the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_hd   <= '0;
            r_out_viol <= 1'b0;
        end else if (w_en) begin
            r_out_vld <= r_v1;
            if (r_v1) begin
                r_out_hd   <= w_hd;
                r_out_viol <= w_viol;
            end
        end
    end

    // Statistics: clear has priority over a coincident update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_viol_cnt   <= '0;
            r_hd_sum     <= '0;
            r_hd_max     <= '0;
            r_alarm      <= 1'b0;
        end else if (clear) begin
            r_sample_cnt <= '0;
            r_viol_cnt   <= '0;
            r_hd_sum     <= '0;
            r_hd_max     <= '0;
            r_alarm      <= 1'b0;
        end else if (w_load2) begin
            r_sample_cnt <= CNT_W'(sat_add(SAT_MAX_W'(r_sample_cnt), SAT_MAX_W'(1), CNT_W));
            r_viol_cnt   <= CNT_W'(sat_add(SAT_MAX_W'(r_viol_cnt), SAT_MAX_W'(w_viol), CNT_W));
            r_hd_sum     <= CNT_W'(sat_add(SAT_MAX_W'(r_hd_sum), SAT_MAX_W'(w_hd), CNT_W));
            if (w_hd > r_hd_max) begin
                r_hd_max <= w_hd;
            end
            r_alarm <= r_alarm | w_viol;
        end
    end

`ifdef HD_MON_CAPTURE_EN
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic             r_cap_vld;
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic [CNT_W-1:0] r_cap_idx;

    // Raw a/b travel alongside the S1 popcounts so the capture sees the same sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a1 <= '0;
            r_b1 <= '0;
        end else if (w_en & mon.in_valid) begin
            r_a1 <= mon.a;
            r_b1 <= mon.b;
        end
    end

    // Index is the pre-increment sample count, i.e. the 0-based position since reset/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_vld <= 1'b0;
            r_cap_a   <= '0;
            r_cap_b   <= '0;
            r_cap_idx <= '0;
        end else if (clear) begin
            r_cap_vld <= 1'b0;
            r_cap_a   <= '0;
            r_cap_b   <= '0;
            r_cap_idx <= '0;
        end else if (w_load2 & w_viol & ~r_cap_vld) begin
            r_cap_vld <= 1'b1;
            r_cap_a   <= r_a1;
            r_cap_b   <= r_b1;
            r_cap_idx <= r_sample_cnt;
        end
    end

    assign mon.cap_valid = r_cap_vld;
    assign mon.cap_a     = r_cap_a;
    assign mon.cap_b     = r_cap_b;
    assign mon.cap_idx   = r_cap_idx;
`endif

    assign mon.in_ready   = w_en;
    assign mon.out_valid  = r_out_vld;
    assign mon.out_hd     = r_out_hd;
    assign mon.out_viol   = r_out_viol;
    assign mon.sample_cnt = r_sample_cnt;
    assign mon.viol_cnt   = r_viol_cnt;
    assign mon.hd_sum     = r_hd_sum;
    assign mon.hd_max     = r_hd_max;
    assign mon.alarm      = r_alarm;

endmodule

// File: tb/tb_hd_err_monitor.sv
module tb_hd_err_monitor;

    localparam int WIDTH  = 18;
    localparam int THRESH = 6;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    always #5 clk = ~clk;

    hd_err_monitor_if #(.WIDTH(WIDTH), .CNT_W(32)) mon ();
    hd_err_monitor_if #(.WIDTH(WIDTH), .CNT_W(4))  mon4 ();

    hd_err_monitor #(.WIDTH(WIDTH), .THRESH(THRESH), .CNT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .mon   (mon.slave)
    );

    hd_err_monitor #(.WIDTH(WIDTH), .THRESH(THRESH), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .mon   (mon4.slave)
    );

    int     checks   = 0;
    int     failures = 0;
    int     n_out    = 0;
    int     exp_q[$];
    longint m_cnt, m_viol, m_sum, m_max;
    longint m_alarm;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               hd;
        int               viol;
    } vec_t;

    vec_t tbl[8];

    // Reference: count differing bit positions.
    function automatic int hd_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i] != y[i]) n++;
        end
        return n;
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_zero();
        m_cnt = 0; m_viol = 0; m_sum = 0; m_max = 0; m_alarm = 0;
    endtask

    // One cycle: drive at negedge, look at the settled outputs, score the handshakes
    // that the coming posedge will complete.
    task automatic step(input bit iv, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit ordy, input bit clr);
        int h;
        @(negedge clk);
        mon.in_valid  = iv;  mon.a  = av; mon.b  = bv; mon.out_ready  = ordy;
        mon4.in_valid = iv;  mon4.a = av; mon4.b = bv; mon4.out_ready = ordy;
        clear = clr;
        #1;
        chk("in_ready_rule", 64'(mon.in_ready), 64'(!(mon.out_valid && !ordy)));
        if (mon.out_valid && ordy) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got hd %0d, expected no output", mon.out_hd);
            end else begin
                h = exp_q.pop_front();
                chk("sb_out_hd", 64'(mon.out_hd), 64'(h));
                chk("sb_out_viol", 64'(mon.out_viol), 64'(h > THRESH));
            end
        end
        if (iv && mon.in_ready) begin
            h = hd_of(av, bv);
            exp_q.push_back(h);
            m_cnt++;
            if (h > THRESH) begin
                m_viol++;
                m_alarm = 1;
            end
            m_sum += h;
            if (h > m_max) m_max = h;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        chk("drain_timeout", 64'(exp_q.size()), 0);
    endtask

    task automatic do_clear();
        step(1'b0, '0, '0, 1'b1, 1'b1);
        model_zero();
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_sample_cnt"}, 64'(mon.sample_cnt), m_cnt);
        chk({tag, "_viol_cnt"},   64'(mon.viol_cnt),   m_viol);
        chk({tag, "_hd_sum"},     64'(mon.hd_sum),     m_sum);
        chk({tag, "_hd_max"},     64'(mon.hd_max),     m_max);
        chk({tag, "_alarm"},      64'(mon.alarm),      m_alarm);
        chk({tag, "_sample_cnt_w4"}, 64'(mon4.sample_cnt), sat4(m_cnt));
        chk({tag, "_hd_sum_w4"},     64'(mon4.hd_sum),     sat4(m_sum));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               cnt;
        int               base;

        tbl[0] = '{18'h00000, 18'h0007F,  7, 1};
        tbl[1] = '{18'h00000, 18'h0003F,  6, 0};
        tbl[2] = '{18'h3FFFF, 18'h00000, 18, 1};
        tbl[3] = '{18'h15555, 18'h2AAAA, 18, 1};
        tbl[4] = '{18'h12345, 18'h12345,  0, 0};
        tbl[5] = '{18'h20001, 18'h00001,  1, 0};
        tbl[6] = '{18'h00FF0, 18'h0F0F0,  8, 1};
        tbl[7] = '{18'h1C000, 18'h00007,  6, 0};

        rst = 1'b1;
        clear = 1'b0;
        mon.in_valid = 0;  mon.a = '0;  mon.b = '0;  mon.out_ready = 1;
        mon4.in_valid = 0; mon4.a = '0; mon4.b = '0; mon4.out_ready = 1;
        model_zero();
        #2;
        chk("rst_out_valid",  64'(mon.out_valid), 0);
        chk("rst_out_hd",     64'(mon.out_hd), 0);
        chk("rst_out_viol",   64'(mon.out_viol), 0);
        chk("rst_sample_cnt", 64'(mon.sample_cnt), 0);
        chk("rst_hd_max",     64'(mon.hd_max), 0);
        chk("rst_alarm",      64'(mon.alarm), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(mon.in_ready), 1);

        // Directed vectors with cycle-exact latency
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, 1'b1, 1'b0);
            step(1'b0, '0, '0, 1'b1, 1'b0);
            chk("tbl_not_yet_valid", 64'(mon.out_valid), 0);
            step(1'b0, '0, '0, 1'b1, 1'b0);
            chk("tbl_valid", 64'(mon.out_valid), 1);
            chk("tbl_out_hd", 64'(mon.out_hd), 64'(tbl[i].hd));
            chk("tbl_out_viol", 64'(mon.out_viol), 64'(tbl[i].viol));
            if (i == 0) begin
                chk("first_viol_cnt", 64'(mon.viol_cnt), 1);
                chk("first_alarm",    64'(mon.alarm), 1);
                chk("first_hd_max",   64'(mon.hd_max), 7);
            end
        end
        drain();
        chk_stats("tbl");

        // 100 back-to-back beats of HD 2
        do_clear();
        cnt = 0;
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            ra = WIDTH'($urandom());
            step(1'b1, ra, ra ^ 18'h00003, 1'b1, 1'b0);
            if (!mon.in_ready) cnt++;
        end
        drain();
        chk("b2b_in_ready_drops", 64'(cnt), 0);
        chk("b2b_outputs", 64'(n_out - base), 100);
        chk("b2b_sample_cnt", 64'(mon.sample_cnt), 100);
        chk("b2b_hd_sum", 64'(mon.hd_sum), 200);
        chk("b2b_viol_cnt", 64'(mon.viol_cnt), 0);
        chk("b2b_hd_max", 64'(mon.hd_max), 2);

        // Output stall for 5 cycles with a sample held in S2
        do_clear();
        step(1'b1, 18'h00000, 18'h0001F, 1'b1, 1'b0);
        step(1'b1, 18'h3FFFF, 18'h3FFF0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 18'h00000, 18'h000FF, 1'b0, 1'b0);
            chk("stall_in_ready", 64'(mon.in_ready), 0);
            chk("stall_out_valid", 64'(mon.out_valid), 1);
            chk("stall_out_hd", 64'(mon.out_hd), 5);
            chk("stall_sample_cnt", 64'(mon.sample_cnt), 1);
        end
        step(1'b1, 18'h00000, 18'h000FF, 1'b1, 1'b0);
        drain();
        chk_stats("stall");

        // Clear in the same cycle a violating sample loads the output stage
        step(1'b1, 18'h3FFFF, 18'h00000, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("clrhit_out_valid", 64'(mon.out_valid), 1);
        chk("clrhit_out_hd", 64'(mon.out_hd), 18);
        chk("clrhit_viol_cnt", 64'(mon.viol_cnt), 0);
        chk("clrhit_alarm", 64'(mon.alarm), 0);
        chk("clrhit_hd_max", 64'(mon.hd_max), 0);
        chk("clrhit_sample_cnt", 64'(mon.sample_cnt), 0);
        model_zero();
        drain();

        // Saturation with a 4-bit counter build
        do_clear();
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom());
            step(1'b1, ra, ra ^ 18'h00001, 1'b1, 1'b0);
        end
        drain();
        chk("sat_w4_sample_cnt", 64'(mon4.sample_cnt), 15);
        chk("sat_w4_hd_sum", 64'(mon4.hd_sum), 15);
        chk("sat_w4_hd_max", 64'(mon4.hd_max), 1);
        chk("sat_w32_sample_cnt", 64'(mon.sample_cnt), 20);
        chk_stats("sat");

`ifdef HD_MON_CAPTURE_EN
        do_clear();
        step(1'b1, 18'h00000, 18'h00000, 1'b1, 1'b0);
        chk("cap_cleared", 64'(mon.cap_valid), 0);
        step(1'b1, 18'h00000, 18'h00003, 1'b1, 1'b0);
        step(1'b1, 18'h00000, 18'h0003F, 1'b1, 1'b0);
        step(1'b1, 18'h2AAAA, 18'h15555, 1'b1, 1'b0);
        step(1'b1, 18'h00000, 18'h000FF, 1'b1, 1'b0);
        drain();
        chk("cap_valid", 64'(mon.cap_valid), 1);
        chk("cap_idx", 64'(mon.cap_idx), 3);
        chk("cap_a", 64'(mon.cap_a), 64'h2AAAA);
        chk("cap_b", 64'(mon.cap_b), 64'h15555);
`endif

        // Randomized traffic with random backpressure against the reference model
        do_clear();
        for (int i = 0; i < 400; i++) begin
            ra = WIDTH'($urandom());
            rb = ra ^ (WIDTH'($urandom()) & WIDTH'($urandom()));
            step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, 1'b0);
        end
        drain();
        chk_stats("rand");

        // Asynchronous reset with two beats in flight
        step(1'b1, 18'h00000, 18'h000FF, 1'b1, 1'b0);
        step(1'b1, 18'h00000, 18'h00FFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("arst_pre_valid", 64'(mon.out_valid), 1);
        rst = 1'b1;
        mon.in_valid = 0;
        mon4.in_valid = 0;
        #1;
        chk("arst_out_valid", 64'(mon.out_valid), 0);
        chk("arst_sample_cnt", 64'(mon.sample_cnt), 0);
        chk("arst_viol_cnt", 64'(mon.viol_cnt), 0);
        chk("arst_hd_sum", 64'(mon.hd_sum), 0);
        chk("arst_hd_max", 64'(mon.hd_max), 0);
        chk("arst_alarm", 64'(mon.alarm), 0);
        exp_q.delete();
        model_zero();
        base = n_out;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("arst_no_output", 64'(n_out - base), 0);
        chk("arst_in_ready", 64'(mon.in_ready), 1);
        chk_stats("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
